// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch pair queue and the issue stage.
//   XLEN       : instruction and PC width
//   OP_*       : RV32 major opcodes that the pair hazard check needs to recognise
//   fq_entry_t : one queue entry, a PC and the instruction fetched from it
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/pair_hazard_check.sv
// Decides whether two program-order adjacent instructions may issue together.
// The issue stage uses this same block, so the queue and the issue stage always
// agree on whether slot 2 is offered.
//   instr1 : older instruction (in slot 1)
//   instr2 : younger instruction (in slot 2)
//   hazard : 1 when the pair must not dual-issue
module pair_hazard_check
    import fetch_pkg::*;
#(
    parameter int XLEN = fetch_pkg::XLEN
) (
    input  logic [XLEN-1:0] instr1,
    input  logic [XLEN-1:0] instr2,
    output logic            hazard
);

    logic [6:0] op1_s;
    logic [6:0] op2_s;
    logic [4:0] rd1_s;
    logic [4:0] rd2_s;
    logic [4:0] rs1_2_s;
    logic [4:0] rs2_2_s;
    logic       ctrl_s;
    logic       mem1_s;
    logic       mem2_s;
    logic       writes1_s;
    logic       uses_rs2_s;
    logic       raw_s;
    logic       waw_s;
    logic       unused_bits_s;

    assign op1_s   = instr1[6:0];
    assign op2_s   = instr2[6:0];
    assign rd1_s   = instr1[11:7];
    assign rd2_s   = instr2[11:7];
    assign rs1_2_s = instr2[19:15];
    assign rs2_2_s = instr2[24:20];

    // funct fields and the upper bits do not affect pairing
    assign unused_bits_s = ^{instr1[XLEN-1:12], instr2[XLEN-1:25], instr2[14:12]};

    // Classify the older instruction.
    always_comb begin
        ctrl_s    = 1'b0;
        mem1_s    = 1'b0;
        writes1_s = 1'b0;
        case (op1_s)
            OP_BRANCH: ctrl_s = 1'b1;
            OP_JAL:    ctrl_s = 1'b1;
            OP_JALR:   ctrl_s = 1'b1;
            OP_LOAD:   mem1_s = 1'b1;
            OP_STORE:  mem1_s = 1'b1;
            default:   ctrl_s = 1'b0;
        endcase
        // BRANCH and STORE carry immediate bits in the rd field
        if ((rd1_s != 5'd0) && (op1_s != OP_BRANCH) && (op1_s != OP_STORE)) begin
            writes1_s = 1'b1;
        end else begin
            writes1_s = 1'b0;
        end
    end

    // Classify the younger instruction.
    always_comb begin
        mem2_s     = 1'b0;
        uses_rs2_s = 1'b0;
        case (op2_s)
            OP_LOAD:   mem2_s     = 1'b1;
            OP_STORE: begin
                mem2_s     = 1'b1;
                uses_rs2_s = 1'b1;
            end
            OP_RTYPE:  uses_rs2_s = 1'b1;
            OP_BRANCH: uses_rs2_s = 1'b1;
            default:   uses_rs2_s = 1'b0;
        endcase
    end

    // Combine the individual hazard sources.
    always_comb begin
        raw_s = 1'b0;
        if (writes1_s) begin
            raw_s = (rs1_2_s == rd1_s) || (uses_rs2_s && (rs2_2_s == rd1_s));
        end else begin
            raw_s = 1'b0;
        end
        waw_s  = (rd1_s != 5'd0) && (rd2_s != 5'd0) && (rd1_s == rd2_s);
        hazard = ctrl_s || (mem1_s && mem2_s) || raw_s || waw_s;
    end

endmodule

// File: rtl/fetch_pair_queue.sv
// Decoupling queue between dual-port instruction fetch and decode/issue.
// A fetched pair (pc, pc+4) is pushed whole; the oldest one or two entries are
// presented every cycle, slot 2 only when the pair is free of hazards.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : clear all entries (branch redirect), beats push/pop
//   in_valid/in_ready   : fetch pair handshake; in_ready needs room for two
//   in_pc, in_instr1/2  : pair payload, instr2 lives at in_pc+4
//   issue_ready         : issue consumes every presented valid slot
//   out_valid1/2, out_instr1/2, out_pc1/2 : issue slots (combinational from storage)
//   count               : current occupancy
module fetch_pair_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr1,
    input  logic [XLEN-1:0]            in_instr2,
    output logic                       in_ready,
    input  logic                       issue_ready,
    output logic                       out_valid1,
    output logic [XLEN-1:0]            out_instr1,
    output logic [XLEN-1:0]            out_pc1,
    output logic                       out_valid2,
    output logic [XLEN-1:0]            out_instr2,
    output logic [XLEN-1:0]            out_pc2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   head_d;
    logic [PW-1:0]   tail_q;
    logic [PW-1:0]   tail_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic [PW-1:0]   head_p1_s;
    logic [PW-1:0]   tail_p1_s;
    logic            push_s;
    logic [1:0]      pop_n_s;
    logic            hazard_s;
    fq_entry_t       slot1_s;
    fq_entry_t       slot2_s;

    // Power-of-two depth: pointer arithmetic wraps by truncation.
    assign head_p1_s = head_q + PW'(1);
    assign tail_p1_s = tail_q + PW'(1);

    assign slot1_s = mem_q[head_q];
    assign slot2_s = mem_q[head_p1_s];

    pair_hazard_check #(
        .XLEN (XLEN)
    ) u_hazard (
        .instr1 (slot1_s.instr),
        .instr2 (slot2_s.instr),
        .hazard (hazard_s)
    );

    // Handshake, slot valids and pop size; in_ready looks at registered count only.
    always_comb begin
        in_ready   = (count_q <= CW'(DEPTH - 2));
        out_valid1 = (count_q >= CW'(1));
        out_valid2 = (count_q >= CW'(2)) && !hazard_s;
        push_s     = in_valid && in_ready && !flush;
        if (issue_ready) begin
            pop_n_s = {1'b0, out_valid1} + {1'b0, out_valid2};
        end else begin
            pop_n_s = 2'd0;
        end
        out_instr1 = slot1_s.instr;
        out_pc1    = slot1_s.pc;
        out_instr2 = slot2_s.instr;
        out_pc2    = slot2_s.pc;
        count      = count_q;
    end

    // Next pointers and occupancy; flush wins over push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_n_s);
            if (push_s) begin
                tail_d  = tail_q + PW'(2);
                count_d = count_q + CW'(2) - CW'(pop_n_s);
            end else begin
                tail_d  = tail_q;
                count_d = count_q - CW'(pop_n_s);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[tail_q]    <= '{pc: in_pc,          instr: in_instr1};
            mem_q[tail_p1_s] <= '{pc: in_pc + 32'd4,  instr: in_instr2};
        end
    end

endmodule
